con_eval_unit: RTL and testbench

Parametrised successor to the single-bit conditional-branch flip-flop in the datapath control path. It evaluates eight branch conditions on operands sampled from the shared bus: four unary tests on one operand and four two-operand compares that take a second operand on a later bus cycle. It registers the branch decision with a one-cycle valid strobe for the control sequencer and keeps a saturating taken-branch counter for performance monitoring.

---
 rtl/con_eval_unit.sv | 118 +++++++++++
 tb/tb_con_eval_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/con_eval_unit.sv
// Branch condition evaluator. It captures operand A and a condition code from
// the shared bus, and optionally operand B. It registers the branch decision
// with a one-cycle valid strobe. It also keeps a saturating count of taken
// branches.
module con_eval_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [2:0]            IR_Bits,
  input  logic [DATA_WIDTH-1:0] Bus_Data,
  input  logic                  CON_In,
  input  logic                  B_In,
  input  logic                  Cnt_Clr,
  output logic                  CON_Out,
  output logic                  CON_Valid,
  output logic                  Busy,
  output logic [CNT_WIDTH-1:0]  Taken_Count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EVAL   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] a_reg, b_reg;
  logic [2:0]            code_reg;
  logic                  load_a, load_b;
  logic                  flag;
  logic                  cnt_full;

  // State register
  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and operand load enables.
  // In WAIT_B, a new CON_In behaves exactly as it does from IDLE, and it takes
  // priority over B_In.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    unique case (state)
      IDLE, WAIT_B: begin
        if (CON_In) begin
          load_a     = 1'b1;
          state_next = IR_Bits[2] ? WAIT_B : EVAL;
        end else if (state == WAIT_B && B_In) begin
          load_b     = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand and condition-code registers
  always_ff @(posedge clock) begin
    if (!clear) begin
      a_reg    <= '0;
      b_reg    <= '0;
      code_reg <= '0;
    end else begin
      if (load_a) begin
        a_reg    <= Bus_Data;
        code_reg <= IR_Bits;
      end
      if (load_b) b_reg <= Bus_Data;
    end
  end

  // Condition decode from the registered operands. The signed compares are
  // true two's-complement compares, so they cannot overflow.
  always_comb begin
    flag = 1'b0;
    unique case (code_reg)
      3'b000: flag = (a_reg == '0);
      3'b001: flag = (a_reg != '0);
      3'b010: flag = ~a_reg[DATA_WIDTH-1];
      3'b011: flag = a_reg[DATA_WIDTH-1];
      3'b100: flag = (a_reg == b_reg);
      3'b101: flag = (a_reg != b_reg);
      3'b110: flag = ($signed(a_reg) <  $signed(b_reg));
      3'b111: flag = ($signed(a_reg) >= $signed(b_reg));
      default: flag = 1'b0;
    endcase
  end

  // Decision register and one-cycle valid strobe
  always_ff @(posedge clock) begin
    if (!clear) begin
      CON_Out   <= 1'b0;
      CON_Valid <= 1'b0;
    end else begin
      CON_Valid <= (state == EVAL);
      if (state == EVAL) CON_Out <= flag;
    end
  end

  assign cnt_full = (Taken_Count == '1);

  // Saturating taken-branch counter. A clear request overrides an increment.
  always_ff @(posedge clock) begin
    if (!clear || Cnt_Clr)
      Taken_Count <= '0;
    else if (state == EVAL && flag && !cnt_full)
      Taken_Count <= Taken_Count + CNT_WIDTH'(1);
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_con_eval_unit.sv
// Scoreboard bench for con_eval_unit. The main instance uses the default
// widths. A second instance has a 2-bit counter and shares the same stimulus.
module tb_con_eval_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  IR_Bits = '0;
  logic [31:0] Bus_Data = '0;
  logic        CON_In = 1'b0, B_In = 1'b0, Cnt_Clr = 1'b0;
  logic        con_out, con_valid, busy;
  logic [15:0] cnt16;
  logic        con_out2, con_valid2, busy2;
  logic [1:0]  cnt2;

  con_eval_unit u_dut (
    .clock(clock), .clear(clear), .IR_Bits(IR_Bits), .Bus_Data(Bus_Data),
    .CON_In(CON_In), .B_In(B_In), .Cnt_Clr(Cnt_Clr),
    .CON_Out(con_out), .CON_Valid(con_valid), .Busy(busy), .Taken_Count(cnt16)
  );

  con_eval_unit #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_dut2 (
    .clock(clock), .clear(clear), .IR_Bits(IR_Bits), .Bus_Data(Bus_Data),
    .CON_In(CON_In), .B_In(B_In), .Cnt_Clr(Cnt_Clr),
    .CON_Out(con_out2), .CON_Valid(con_valid2), .Busy(busy2), .Taken_Count(cnt2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        out;
    logic [15:0] c16;
    logic [1:0]  c2;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m16 = '0;
  logic [1:0]  m2  = '0;
  logic        prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic ref_flag(input logic [2:0] code, input logic [31:0] a,
                                    input logic [31:0] b);
    case (code)
      3'd0: return a == 32'd0;
      3'd1: return a != 32'd0;
      3'd2: return a[31] == 1'b0;
      3'd3: return a[31] == 1'b1;
      3'd4: return a == b;
      3'd5: return a != b;
      3'd6: return $signed(a) < $signed(b);
      default: return $signed(a) >= $signed(b);
    endcase
  endfunction

  task automatic push_exp(input logic f, input bit clr);
    exp_t e;
    if (clr) begin
      m16 = '0;
      m2  = '0;
    end else if (f) begin
      if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
      if (m2  != 2'd3)     m2  = m2 + 2'd1;
    end
    e.out = f; e.c16 = m16; e.c2 = m2;
    sb.push_back(e);
  endtask

  // Every valid pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (con_valid) begin
      check("valid_back_to_back", {31'd0, prev_valid}, 32'd0);
      check("valid2", {31'd0, con_valid2}, 32'd1);
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("con_out",  {31'd0, con_out},  {31'd0, e.out});
        check("con_out2", {31'd0, con_out2}, {31'd0, e.out});
        check("count16",  {16'd0, cnt16},    {16'd0, e.c16});
        check("count2",   {30'd0, cnt2},     {30'd0, e.c2});
      end
    end
    prev_valid = con_valid;
  end

  task automatic chk_busy_valid(input string tag, input logic b, input logic v);
    check({tag, "_busy"},  {31'd0, busy},      {31'd0, b});
    check({tag, "_busy2"}, {31'd0, busy2},     {31'd0, b});
    check({tag, "_valid"}, {31'd0, con_valid}, {31'd0, v});
  endtask

  task automatic unary(input logic [2:0] code, input logic [31:0] a, input bit clr);
    @(negedge clock);
    IR_Bits = code; Bus_Data = a; CON_In = 1'b1;
    @(posedge clock); #1;
    CON_In = 1'b0; Bus_Data = $urandom; IR_Bits = 3'($urandom);
    chk_busy_valid("u_eval", 1'b1, 1'b0);
    @(negedge clock);
    B_In = 1'b1;              // B_In is ignored in EVAL
    Cnt_Clr = clr;
    push_exp(ref_flag(code, a, 32'd0), clr);
    @(posedge clock); #1;
    B_In = 1'b0; Cnt_Clr = 1'b0;
    chk_busy_valid("u_done", 1'b0, 1'b1);
  endtask

  task automatic compare(input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int gap);
    @(negedge clock);
    IR_Bits = code; Bus_Data = a; CON_In = 1'b1;
    @(posedge clock); #1;
    CON_In = 1'b0; Bus_Data = $urandom;
    chk_busy_valid("c_waitb", 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) begin
      @(posedge clock); #1;
      chk_busy_valid("c_wait", 1'b1, 1'b0);
    end
    @(negedge clock);
    Bus_Data = b; B_In = 1'b1;
    push_exp(ref_flag(code, a, b), 1'b0);
    @(posedge clock); #1;
    B_In = 1'b0; Bus_Data = $urandom;
    chk_busy_valid("c_eval", 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_busy_valid("c_done", 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_busy_valid("reset", 1'b0, 1'b0);
    check("reset_out", {31'd0, con_out}, 32'd0);
    check("reset_cnt", {16'd0, cnt16}, 32'd0);
    check("reset_cnt2", {30'd0, cnt2}, 32'd0);
    clear = 1'b1;

    unary(3'b000, 32'd0, 1'b0);

    // Explicit counter clear
    @(negedge clock); Cnt_Clr = 1'b1; m16 = '0; m2 = '0;
    @(posedge clock); #1; Cnt_Clr = 1'b0;
    check("cnt_clr", {16'd0, cnt16}, 32'd0);

    unary(3'b011, 32'h8000_0000, 1'b0);
    unary(3'b010, 32'h8000_0000, 1'b0);
    check("neg_pos_cnt", {16'd0, cnt16}, 32'd1);
    unary(3'b001, 32'd0, 1'b0);

    compare(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    compare(3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 2);
    compare(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    compare(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1);
    compare(3'b100, 32'd5, 32'd5, 0);
    compare(3'b101, 32'd5, 32'd5, 0);

    // Abort in WAIT_B: the new CON_In wins over the simultaneous B_In
    @(negedge clock);
    IR_Bits = 3'b100; Bus_Data = 32'd3; CON_In = 1'b1;
    @(posedge clock); #1;
    CON_In = 1'b0;
    chk_busy_valid("abort_waitb", 1'b1, 1'b0);
    @(negedge clock);
    IR_Bits = 3'b000; Bus_Data = 32'd0; CON_In = 1'b1; B_In = 1'b1;
    push_exp(1'b1, 1'b0);
    @(posedge clock); #1;
    CON_In = 1'b0; B_In = 1'b0; Bus_Data = 32'd3;
    chk_busy_valid("abort_eval", 1'b1, 1'b0);
    @(posedge clock); #1;
    chk_busy_valid("abort_done", 1'b0, 1'b1);
    repeat (3) @(posedge clock);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) unary(3'b001, 32'd7 + 32'(i), 1'b0);
    check("sat_cnt2", {30'd0, cnt2}, 32'd3);

    // Clear wins over a simultaneous increment
    unary(3'b000, 32'd0, 1'b1);
    check("clr_vs_inc", {16'd0, cnt16}, 32'd0);
    unary(3'b011, 32'h8000_0001, 1'b0);

    // Reset while waiting for B discards the evaluation
    @(negedge clock);
    IR_Bits = 3'b100; Bus_Data = 32'd3; CON_In = 1'b1;
    @(posedge clock); #1;
    CON_In = 1'b0;
    @(negedge clock); clear = 1'b0; B_In = 1'b1; Bus_Data = 32'd3;
    @(posedge clock); #1;
    clear = 1'b1; B_In = 1'b0; m16 = '0; m2 = '0;
    chk_busy_valid("rst_waitb", 1'b0, 1'b0);
    check("rst_out", {31'd0, con_out}, 32'd0);
    check("rst_cnt", {16'd0, cnt16}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk_busy_valid("rst_quiet", 1'b0, 1'b0);
    end

    // Random mix
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  c;
      logic [31:0] a, b;
      c = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (c[2]) compare(c, a, b, $urandom_range(0, 2));
      else      unary(c, a, 1'b0);
    end

    repeat (3) @(posedge clock);
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
